// File: rtl/sequencer_recorder.sv
`default_nettype none
// sequencer_recorder -- live-records keypad notes into a STEPS-slot pattern quantised to
// beat pulses, then loops the pattern out as SUSTAIN-cycle notes.  Rev 1.0
module sequencer_recorder #(
  parameter int STEPS   = 8,
  parameter int SUSTAIN = 2000
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic [3:0]               note_in,
  input  logic                     beat_pulse,
  input  logic                     play,
  input  logic                     rec_arm,
  input  logic                     clear,
  output logic [3:0]               note_out,
  output logic [$clog2(STEPS)-1:0] step,
  output logic                     recording,
  output logic                     armed,
  output logic [STEPS-1:0]         pattern_valid
);

  localparam int c_STEP_W = $clog2(STEPS);
  localparam int c_SUS_W  = (SUSTAIN > 1) ? $clog2(SUSTAIN) : 1;

  localparam logic [c_SUS_W-1:0]  c_SUS_LOAD  = c_SUS_W'(SUSTAIN - 1);
  localparam logic [c_STEP_W-1:0] c_LAST_STEP = c_STEP_W'(STEPS - 1);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_ARMED    = 2'd1;
  localparam logic [1:0] c_RECORD   = 2'd2;
  localparam logic [1:0] c_PLAYBACK = 2'd3;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [c_STEP_W-1:0] r_step;
  logic [c_STEP_W-1:0] w_step_inc;
  logic [3:0]          r_slot [STEPS];
  logic [3:0]          r_cap;
  logic [3:0]          w_commit_val;
  logic [c_SUS_W-1:0]  r_sus;
  logic [3:0]          r_note;
  logic                w_beat;
  logic                w_any_slot;
  logic                w_in_record;
  logic                w_commit;

  assign w_beat       = beat_pulse & play;
  assign w_step_inc   = r_step + c_STEP_W'(1);
  assign w_any_slot   = |pattern_valid;
  assign w_in_record  = (r_state == c_RECORD);
  assign w_commit     = w_in_record & w_beat & ~clear;
  assign w_commit_val = (r_cap != 4'd0) ? r_cap : note_in;

  generate
    for (genvar gi = 0; gi < STEPS; gi++) begin : g_valid
      assign pattern_valid[gi] = |r_slot[gi];
    end
  endgenerate

  // With play low every transition except clear is frozen.
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = c_IDLE;
    end else if (play) begin
      case (r_state)
        c_IDLE: begin
          if (rec_arm)         w_state_nxt = c_ARMED;
          else if (w_any_slot) w_state_nxt = c_PLAYBACK;
        end
        c_ARMED: begin
          if (!rec_arm)        w_state_nxt = c_IDLE;
          else if (beat_pulse) w_state_nxt = c_RECORD;
        end
        c_RECORD: begin
          if (!rec_arm)                       w_state_nxt = c_IDLE;
          else if (beat_pulse && r_step == c_LAST_STEP) w_state_nxt = c_PLAYBACK;
        end
        c_PLAYBACK: begin
          if (rec_arm)          w_state_nxt = c_ARMED;
          else if (!w_any_slot) w_state_nxt = c_IDLE;
        end
        default: w_state_nxt = c_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_step <= '0;
    end else if (w_beat) begin
      r_step <= (r_state == c_ARMED) ? '0 : w_step_inc;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < STEPS; i++) r_slot[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < STEPS; i++) r_slot[i] <= '0;
    end else if (w_commit) begin
      r_slot[r_step] <= w_commit_val;
    end
  end

  // Capture holds the first nonzero note of the step; a beat or an abort empties it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cap <= '0;
    end else if (clear || !w_in_record) begin
      r_cap <= '0;
    end else if (play) begin
      if (beat_pulse || !rec_arm) begin
        r_cap <= '0;
      end else if (r_cap == 4'd0) begin
        r_cap <= note_in;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_note <= '0;
      r_sus  <= '0;
    end else if (clear || !play) begin
      r_note <= '0;
      r_sus  <= '0;
    end else begin
      case (r_state)
        c_RECORD: begin
          r_note <= note_in;
          r_sus  <= '0;
        end
        c_PLAYBACK: begin
          if (beat_pulse) begin
            r_note <= r_slot[w_step_inc];
            r_sus  <= c_SUS_LOAD;
          end else if (r_sus != '0) begin
            r_sus  <= r_sus - c_SUS_W'(1);
          end else begin
            r_note <= '0;
          end
        end
        default: begin
          r_note <= '0;
          r_sus  <= '0;
        end
      endcase
    end
  end

  assign note_out  = r_note;
  assign step      = r_step;
  assign recording = (r_state == c_RECORD);
  assign armed     = (r_state == c_ARMED);

endmodule
`default_nettype wire

// File: tb/tb_sequencer_recorder.sv
`default_nettype none
// Bench for sequencer_recorder: two instances (SUSTAIN 4 and 15) share stimulus; every cycle
// a behavioural pattern/sound model queues the expected outputs and a monitor compares them.
module tb_sequencer_recorder;

  localparam int STEPS = 8;
  localparam int SUS0  = 4;
  localparam int SUS1  = 15;
  localparam int M_IDLE = 0, M_ARMED = 1, M_REC = 2, M_PLAY = 3;

  logic       clk = 1'b0;
  logic       n_rst, beat_pulse, play, rec_arm, clear;
  logic [3:0] note_in;
  logic [3:0] note0, note1;
  logic [2:0] step0, step1;
  logic       rec0, rec1, arm0, arm1;
  logic [7:0] pv0, pv1;

  always #5 clk = ~clk;

  sequencer_recorder #(.STEPS(STEPS), .SUSTAIN(SUS0)) dut0 (
    .clk(clk), .n_rst(n_rst), .note_in(note_in), .beat_pulse(beat_pulse), .play(play),
    .rec_arm(rec_arm), .clear(clear), .note_out(note0), .step(step0), .recording(rec0),
    .armed(arm0), .pattern_valid(pv0));

  sequencer_recorder #(.STEPS(STEPS), .SUSTAIN(SUS1)) dut1 (
    .clk(clk), .n_rst(n_rst), .note_in(note_in), .beat_pulse(beat_pulse), .play(play),
    .rec_arm(rec_arm), .clear(clear), .note_out(note1), .step(step1), .recording(rec1),
    .armed(arm1), .pattern_valid(pv1));

  typedef struct packed {
    logic [3:0] n0;
    logic [3:0] n1;
    logic [2:0] st;
    logic       rec;
    logic       arm;
    logic [7:0] pv;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: musical mode, step, pattern, captured note, per-instance sound.
  int m_mode, m_step, m_cap;
  int m_pat[STEPS];
  int m_snd[2];
  int m_rem[2];
  int sus_len[2] = '{SUS0, SUS1};
  int ab_vals[4] = '{9, 10, 11, 12};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_step = 0; m_cap = 0;
    for (int i = 0; i < STEPS; i++) m_pat[i] = 0;
    for (int k = 0; k < 2; k++) begin m_snd[k] = 0; m_rem[k] = 0; end
  endtask

  task automatic model_step(input int n, input int b, input int p, input int a, input int c);
    exp_t e;
    int   nxt, old_mode;
    bit   any;
    nxt      = (m_step + 1) % STEPS;
    old_mode = m_mode;
    any      = 1'b0;
    for (int i = 0; i < STEPS; i++) if (m_pat[i] != 0) any = 1'b1;
    // Sound: m_rem counts cycles still to be heard, including the one being shown.
    for (int k = 0; k < 2; k++) begin
      if (c != 0 || p == 0) begin m_snd[k] = 0; m_rem[k] = 0; end
      else if (m_mode == M_REC) begin m_snd[k] = n; m_rem[k] = 0; end
      else if (m_mode == M_PLAY && b != 0) begin m_snd[k] = m_pat[nxt]; m_rem[k] = sus_len[k]; end
      else if (m_mode == M_PLAY && m_rem[k] > 1) m_rem[k] = m_rem[k] - 1;
      else begin m_snd[k] = 0; m_rem[k] = 0; end
    end
    if (c != 0) begin
      for (int i = 0; i < STEPS; i++) m_pat[i] = 0;
      m_cap = 0; m_mode = M_IDLE;
    end else if (p != 0) begin
      case (m_mode)
        M_IDLE:  if (a != 0) m_mode = M_ARMED; else if (any) m_mode = M_PLAY;
        M_ARMED: if (a == 0) m_mode = M_IDLE; else if (b != 0) m_mode = M_REC;
        M_REC: begin
          if (b != 0) begin
            m_pat[m_step] = (m_cap != 0) ? m_cap : n;
            m_cap = 0;
            if (m_step == STEPS - 1) m_mode = M_PLAY;
          end else if (m_cap == 0) m_cap = n;
          if (a == 0) begin m_mode = M_IDLE; m_cap = 0; end
        end
        default: if (a != 0) m_mode = M_ARMED; else if (!any) m_mode = M_IDLE;
      endcase
    end
    if (p != 0 && b != 0) m_step = (old_mode == M_ARMED) ? 0 : nxt;
    e.n0  = 4'(m_snd[0]);
    e.n1  = 4'(m_snd[1]);
    e.st  = 3'(m_step);
    e.rec = (m_mode == M_REC);
    e.arm = (m_mode == M_ARMED);
    for (int i = 0; i < STEPS; i++) e.pv[i] = (m_pat[i] != 0);
    q.push_back(e);
  endtask

  task automatic tick(input int n, input int b, input int p, input int a, input int c);
    @(negedge clk);
    note_in = 4'(n); beat_pulse = (b != 0); play = (p != 0); rec_arm = (a != 0); clear = (c != 0);
    model_step(n, b, p, a, c);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic beats(input int nb, input int period, input int nt);
    for (int i = 0; i < nb; i++) begin
      for (int c = 1; c < period; c++) tick(nt, 0, 1, 0, 0);
      tick(nt, 1, 1, 0, 0);
    end
  endtask

  task automatic idle_inputs();
    note_in = 4'd0; beat_pulse = 1'b0; play = 1'b0; rec_arm = 1'b0; clear = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_note0"}, 32'(note0), 32'd0);
    chk({tag, "_note1"}, 32'(note1), 32'd0);
    chk({tag, "_step"},  32'(step0), 32'd0);
    chk({tag, "_rec"},   32'(rec0),  32'd0);
    chk({tag, "_armed"}, 32'(arm0),  32'd0);
    chk({tag, "_pv"},    32'(pv0),   32'd0);
  endtask

  function automatic int rec_note(input int s, input int c);
    if (s == 0 && c >= 3 && c <= 5) return 3;
    if (s == 2 && c >= 2 && c <= 3) return 5;
    if (s == 2 && c >= 6 && c <= 7) return 7;
    return 0;
  endfunction

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      chk("note_out_s4",  32'(note0), 32'(mon_e.n0));
      chk("note_out_s15", 32'(note1), 32'(mon_e.n1));
      chk("step",         32'(step0), 32'(mon_e.st));
      chk("step_b",       32'(step1), 32'(mon_e.st));
      chk("recording",    32'(rec0),  32'(mon_e.rec));
      chk("recording_b",  32'(rec1),  32'(mon_e.rec));
      chk("armed",        32'(arm0),  32'(mon_e.arm));
      chk("armed_b",      32'(arm1),  32'(mon_e.arm));
      chk("pattern_valid",   32'(pv0), 32'(mon_e.pv));
      chk("pattern_valid_b", 32'(pv1), 32'(mon_e.pv));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    int arm_lvl;
    n_rst = 1'b0;
    idle_inputs();
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_values("por");
    n_rst = 1'b1;

    // Record pass: 3 in step0, 5 then 7 in step2; rec_arm drops on the final commit.
    repeat (3) tick(0, 0, 1, 1, 0);
    tick(0, 1, 1, 1, 0);
    for (int s = 0; s < STEPS; s++) begin
      for (int c = 1; c < 10; c++) tick(rec_note(s, c), 0, 1, 1, 0);
      tick(0, 1, 1, (s == STEPS - 1) ? 0 : 1, 0);
    end
    settle();
    chk("record_pv", 32'(pv0), 32'h05);
    chk("record_done_rec", 32'(rec0), 32'd0);

    // Playback, then pause mid-sustain in step2 across three beats.
    repeat (2) tick(0, 0, 1, 0, 0);
    beats(18, 10, 0);
    repeat (2) tick(0, 0, 1, 0, 0);
    for (int i = 0; i < 30; i++) tick(0, (i % 10 == 9) ? 1 : 0, 0, 0, 0);
    settle();
    chk("pause_step", 32'(step0), 32'd2);
    chk("pause_note", 32'(note0), 32'd0);
    beats(4, 10, 0);

    // Abort during step4 of a second record pass.
    repeat (3) tick(0, 0, 1, 1, 0);
    tick(0, 1, 1, 1, 0);
    for (int s = 0; s < 4; s++) begin
      for (int c = 1; c < 10; c++) tick((c == 4) ? ab_vals[s] : 0, 0, 1, 1, 0);
      tick(0, 1, 1, 1, 0);
    end
    for (int c = 1; c < 5; c++) tick(6, 0, 1, 1, 0);
    tick(0, 0, 1, 0, 0);
    settle();
    chk("abort_pv", 32'(pv0), 32'h0F);
    chk("abort_rec", 32'(rec0), 32'd0);
    repeat (3) tick(0, 0, 1, 0, 0);
    beats(10, 10, 0);

    // Clear while playing.
    repeat (3) tick(0, 0, 1, 0, 0);
    tick(0, 0, 1, 0, 1);
    repeat (3) tick(0, 0, 1, 0, 0);
    settle();
    chk("clear_pv", 32'(pv0), 32'd0);
    chk("clear_note0", 32'(note0), 32'd0);
    chk("clear_note1", 32'(note1), 32'd0);
    chk("clear_armed", 32'(arm0), 32'd0);

    // Randomised phase: irregular beats, pauses, arm toggles, occasional clears.
    arm_lvl = 0;
    for (int i = 0; i < 90; i++) begin
      int period, pl;
      period = int'($urandom_range(2, 14));
      if ($urandom_range(0, 7) == 0) arm_lvl = 1 - arm_lvl;
      pl = ($urandom_range(0, 9) != 0) ? 1 : 0;
      for (int c = 1; c < period; c++)
        tick(($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 15)) : 0, 0, pl, arm_lvl,
             ($urandom_range(0, 150) == 0) ? 1 : 0);
      tick(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 0, 1, pl, arm_lvl, 0);
    end

    // Asynchronous reset in the middle of a record pass.
    repeat (3) tick(0, 0, 1, 0, 0);
    repeat (3) tick(0, 0, 1, 1, 0);
    tick(0, 1, 1, 1, 0);
    for (int c = 1; c < 10; c++) tick(4, 0, 1, 1, 0);
    tick(0, 1, 1, 1, 0);
    for (int c = 1; c < 5; c++) tick(8, 0, 1, 1, 0);
    @(posedge clk);
    #3;
    chk("pre_reset_rec", 32'(rec0), 32'd1);
    n_rst = 1'b0;
    #1;
    chk_reset_values("async");
    idle_inputs();
    model_reset();
    q.delete();
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    beats(3, 7, 0);
    repeat (5) tick(0, 0, 1, 0, 0);
    @(posedge clk);
    #3;
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
